pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/struct_pkg.sv | 30 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/struct_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The state encoding is architecturally visible on the state port.
package struct_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // Bundle of all stage-register controls, MSB first: enables then flushes.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = ctrl_t'(7'b1111100);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000000);
  localparam ctrl_t CTRL_RESET = ctrl_t'(7'b0000011);

  // Cycles the back end keeps advancing after a halt so older instructions retire.
  localparam logic [1:0] HALT_DRAIN = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables/flushes from hazards, branches, memory waits, halt.
// Controls are combinational from state and inputs; state, drain/flush counter and halted are registered.
module pipeline_ctrl
  import struct_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lu_hazard,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

  state_e     st, st_nxt;
  logic [1:0] cnt, cnt_nxt;
  ctrl_t      ctrl;
  logic       flush_inc;
  logic       stall_inc;
  logic       clr;

  always_comb begin
    ctrl      = CTRL_RUN;
    st_nxt    = st;
    cnt_nxt   = cnt;
    flush_inc = 1'b0;
    if (!rst_n) begin
      ctrl    = CTRL_RESET;
      st_nxt  = ST_RUN;
      cnt_nxt = 2'd0;
    end else begin
      case (st)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            ctrl   = CTRL_FREEZE;
            st_nxt = ST_MEM_WAIT;
          end else if (branch_taken) begin
            // A branch also squashes any load-use-stalled instruction in ID.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            flush_inc       = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              st_nxt  = ST_FLUSH;
              cnt_nxt = FLUSH_LD;
            end
          end else if (halt_req) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
            st_nxt          = ST_HALT;
            cnt_nxt         = HALT_DRAIN;
          end else if (lu_hazard) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end else if (!imem_ready) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            ctrl = CTRL_FREEZE;
          end else begin
            st_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ctrl.ifid_flush = 1'b1;
          cnt_nxt         = cnt - 2'd1;
          if (cnt <= 2'd1) begin
            st_nxt = ST_RUN;
          end
        end
        default: begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_en    = 1'b0;
          ctrl.ifid_flush = 1'b1;
          if (cnt == 2'd0) begin
            ctrl.idex_en  = 1'b0;
            ctrl.exmem_en = 1'b0;
            ctrl.memwb_en = 1'b0;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= ST_RUN;
      cnt    <= 2'd0;
      halted <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if ((st == ST_HALT) && (cnt == 2'd1)) begin
        halted <= 1'b1;
      end
    end
  end

  assign clr       = ~rst_n;
  assign stall_inc = ~ctrl.pc_en && (st != ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (clr),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (clr),
    .inc   (flush_inc),
    .value (flush_cnt)
  );

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign state      = st;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, all checked each cycle
// against a mode/countdown reference model.
module tb_pipeline_ctrl;

  localparam int FC  = 1;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, lu_hazard, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0]    state;
  logic          halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lu_hazard    (lu_hazard),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which situation the pipeline is in, plus remaining counts.
  bit m_wait;
  bit m_halting;
  int m_flush_left;
  int m_drain;
  int m_stall;
  int m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_wait       = 1'b0;
    m_halting    = 1'b0;
    m_flush_left = 0;
    m_drain      = 0;
    m_stall      = 0;
    m_flush      = 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // One cycle: drive, check outputs mid-cycle, advance the model, move past the edge.
  task automatic step(input bit r, input bit hq, input bit br, input bit lu,
                      input bit im, input bit dq, input bit dr);
    logic [6:0] e;
    int         exp_state;
    rst_n = r; halt_req = hq; branch_taken = br; lu_hazard = lu;
    imem_ready = im; dmem_req = dq; dmem_ready = dr;
    @(negedge clk);
    if (!r)                    e = 7'b0000011;
    else if (m_halting)        e = (m_drain > 0) ? 7'b0011110 : 7'b0000010;
    else if (m_wait)           e = dr ? 7'b1111100 : 7'b0000000;
    else if (m_flush_left > 0) e = 7'b1111110;
    else if (dq && !dr)        e = 7'b0000000;
    else if (br)               e = 7'b1111111;
    else if (hq)               e = 7'b0111110;
    else if (lu)               e = 7'b0011101;
    else if (!im)              e = 7'b0111110;
    else                       e = 7'b1111100;
    exp_state = m_halting ? 3 : m_wait ? 1 : (m_flush_left > 0) ? 2 : 0;
    chk("ctrl", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}), 32'(e));
    chk("state", 32'(state), 32'(exp_state));
    chk("halted", 32'(halted), 32'(m_halting && (m_drain == 0)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (!r) begin
      model_reset();
    end else begin
      if (!e[6] && !m_halting) m_stall = sat_inc(m_stall);
      if (m_halting) begin
        if (m_drain > 0) m_drain--;
      end else if (m_wait) begin
        if (dr) m_wait = 1'b0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (dq && !dr) begin
        m_wait = 1'b1;
      end else if (br) begin
        m_flush      = sat_inc(m_flush);
        m_flush_left = FC;
      end else if (hq) begin
        m_halting = 1'b1;
        m_drain   = 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 1, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; halt_req = 1'b0; branch_taken = 1'b0; lu_hazard = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    do_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    idle();

    // Load-use for one cycle.
    step(1, 0, 0, 1, 1, 0, 1);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    idle();

    // Taken branch with one extra squash cycle.
    step(1, 0, 1, 0, 1, 0, 1);
    chk("br_state", 32'(state), 32'd2);
    idle();
    chk("br_back", 32'(state), 32'd0);
    idle();
    chk("br_flush", 32'(flush_cnt), 32'd1);

    // Data memory wait of four cycles.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 1, 1);
    chk("mw_stall", 32'(stall_cnt), 32'd4);

    // Memory wait outranks branch and load-use; branch taken after ready.
    do_reset();
    step(1, 0, 1, 1, 1, 1, 0);
    chk("pri_state", 32'(state), 32'd1);
    chk("pri_flush", 32'(flush_cnt), 32'd0);
    step(1, 0, 1, 0, 1, 1, 1);
    step(1, 0, 1, 0, 1, 0, 1);
    chk("pri_br", 32'(flush_cnt), 32'd1);
    idle();

    // Halt drains three cycles, then freezes until reset.
    do_reset();
    step(1, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) idle();
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_flag", 32'(halted), 32'd1);
    do_reset();
    chk("halt_rst", 32'(state), 32'd0);
    chk("halt_rst_cnt", 32'(stall_cnt), 32'd0);

    // Stall counter saturation.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 1);
    chk("sat_stall", 32'(stall_cnt), 32'(SAT));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) >= 3,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) >= 15,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
